// File: rtl/simple_exec_unit.sv
// Execute/write-back stage: read operands, compute ALU or iterative MUL result, write back.
// Latency: write lands 3 cycles after handshake (11 for MUL); instr_ready is held low while busy.
module simple_exec_unit #(
    parameter int MUL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [3:0] instr_rd,
    input  logic [3:0] instr_rn,
    input  logic [3:0] instr_rm,
    input  logic [7:0] instr_imm,
    output logic [3:0] regf_raddrN,
    output logic [3:0] regf_raddrM,
    input  logic [7:0] regf_rdoutN,
    input  logic [7:0] regf_rdoutM,
    output logic       regf_wren,
    output logic [3:0] regf_waddr,
    output logic [7:0] regf_wdin,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v,
    output logic       done,
    output logic       illegal_op
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOVI = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [2:0] MUL_LAST = 3'(MUL_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  op_q, rd_q;
    logic [7:0]  imm_q;
    logic [7:0]  result_q;
    logic        wr_q, ill_q;
    logic [15:0] mcand_q, acc_q;
    logic [7:0]  mplr_q;
    logic        neg_q;
    logic [2:0]  cnt_q;

    logic [7:0]  alu_res, sum, diff, mag_n, mag_m;
    logic        alu_v, alu_wr, alu_ill;
    logic [15:0] acc_nxt, prod;
    logic        mul_v;

    assign sum   = regf_rdoutN + regf_rdoutM;
    assign diff  = regf_rdoutN - regf_rdoutM;
    // -128 maps to 8'h80 which reads correctly as unsigned 128
    assign mag_n = regf_rdoutN[7] ? 8'(-regf_rdoutN) : regf_rdoutN;
    assign mag_m = regf_rdoutM[7] ? 8'(-regf_rdoutM) : regf_rdoutM;

    assign acc_nxt = acc_q + (mplr_q[0] ? mcand_q : 16'd0);
    assign prod    = neg_q ? 16'(-acc_nxt) : acc_nxt;
    assign mul_v   = !((&prod[15:7]) || !(|prod[15:7]));

    always_comb begin
        alu_res = 8'd0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        alu_ill = 1'b0;
        case (op_q)
            OP_NOP:  alu_wr = 1'b0;
            OP_ADD: begin
                alu_res = sum;
                alu_v   = (regf_rdoutN[7] == regf_rdoutM[7]) && (sum[7] != regf_rdoutN[7]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_v   = (regf_rdoutN[7] != regf_rdoutM[7]) && (diff[7] != regf_rdoutN[7]);
            end
            OP_AND:  alu_res = regf_rdoutN & regf_rdoutM;
            OP_OR:   alu_res = regf_rdoutN | regf_rdoutM;
            OP_XOR:  alu_res = regf_rdoutN ^ regf_rdoutM;
            OP_MOVI: alu_res = imm_q;
            OP_MUL:  alu_res = 8'd0;
            OP_SHL:  alu_res = regf_rdoutN << regf_rdoutM[2:0];
            OP_ASR:  alu_res = $unsigned($signed(regf_rdoutN) >>> regf_rdoutM[2:0]);
            default: begin
                alu_wr  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (instr_valid) state_nxt = READ;
            READ: state_nxt = EXEC;
            EXEC: state_nxt = (op_q == OP_MUL) ? MUL : WB;
            MUL:  if (cnt_q == MUL_LAST) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);
    assign done        = (state == WB);
    assign illegal_op  = (state == WB) && ill_q;
    assign regf_wren   = (state == WB) && wr_q;
    assign regf_waddr  = (state == WB) ? rd_q : 4'd0;
    assign regf_wdin   = (state == WB) ? result_q : 8'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            op_q        <= 4'd0;
            rd_q        <= 4'd0;
            imm_q       <= 8'd0;
            regf_raddrN <= 4'd0;
            regf_raddrM <= 4'd0;
            result_q    <= 8'd0;
            wr_q        <= 1'b0;
            ill_q       <= 1'b0;
            mcand_q     <= 16'd0;
            acc_q       <= 16'd0;
            mplr_q      <= 8'd0;
            neg_q       <= 1'b0;
            cnt_q       <= 3'd0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_v      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (instr_valid) begin
                    op_q        <= instr_op;
                    rd_q        <= instr_rd;
                    imm_q       <= instr_imm;
                    regf_raddrN <= instr_rn;
                    regf_raddrM <= instr_rm;
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
                        mcand_q <= {8'd0, mag_n};
                        mplr_q  <= mag_m;
                        acc_q   <= 16'd0;
                        neg_q   <= regf_rdoutN[7] ^ regf_rdoutM[7];
                        cnt_q   <= 3'd0;
                        wr_q    <= 1'b1;
                        ill_q   <= 1'b0;
                    end else begin
                        result_q <= alu_res;
                        wr_q     <= alu_wr;
                        ill_q    <= alu_ill;
                        if (alu_wr) begin
                            flag_z <= (alu_res == 8'd0);
                            flag_n <= alu_res[7];
                            flag_v <= alu_v;
                        end
                    end
                end
                MUL: begin
                    acc_q   <= acc_nxt;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == MUL_LAST) begin
                        result_q <= prod[7:0];
                        flag_z   <= (prod[7:0] == 8'd0);
                        flag_n   <= prod[7];
                        flag_v   <= mul_v;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/simple_exec_unit.md
Name: simple_exec_unit

Overview:
Execute/write-back stage directly downstream of the 16x8 signed register file; consumes both read ports and drives the single write port. Accepts one decoded instruction per valid/ready handshake, issues operand reads, computes the ALU result (iterative multiply for MUL), and writes it back. Instructions are strictly serialised, so no forwarding is needed: every write lands before the next read is issued.

Parameters:
MUL_CYCLES, 8, iterations of the shift-add multiplier. Fixed to the 8-bit operand width; other values are unsupported.

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  unit can accept
instr_op  input  4  opcode
instr_rd  input  4  destination register
instr_rn  input  4  source N register
instr_rm  input  4  source M register
instr_imm  input  8  signed immediate, MOVI only
regf_raddrN  output  4  register file read address N
regf_raddrM  output  4  register file read address M
regf_rdoutN  input  8  signed operand N, registered by the register file
regf_rdoutM  input  8  signed operand M, registered by the register file
regf_wren  output  1  register file write enable
regf_waddr  output  4  write address
regf_wdin  output  8  signed write data
flag_z  output  1  last result zero
flag_n  output  1  last result negative
flag_v  output  1  last signed overflow
done  output  1  one-cycle pulse at instruction retire
illegal_op  output  1  one-cycle pulse, coincides with done

Behaviour:
- Reset (async, resetn=0): state=IDLE; instr_ready=1; regf_wren=0; regf_waddr/regf_wdin/regf_raddrN/regf_raddrM=0; flags=0; done=0; illegal_op=0.
- Reset mid-instruction: the instruction is aborted and no write occurs, including when resetn is asserted in the WB state.
- instr_ready=1 only in IDLE. The handshake completes on an edge with valid&&ready. op/rd/rn/rm/imm are latched on that edge.
- FSM states: IDLE, READ, EXEC, MUL, WB.
  - IDLE -> READ on handshake.
  - READ: raddrN=rn, raddrM=rm; the register file samples them at the end of READ. Always -> EXEC.
  - EXEC: regf_rdoutN/M are valid. For single-cycle ops, register the result and go -> WB. For MUL, capture operands and go -> MUL.
  - MUL: runs MUL_CYCLES cycles, then -> WB.
  - WB: regf_wren=1 for exactly this cycle (0 for NOP and illegal ops); done=1. Always -> IDLE.
- Latency: handshake edge E0, write lands at E3 for single-cycle ops and at E3+8 for MUL. The next handshake is at the earliest at E4 (E4+8 for MUL).
- Read addresses are held at their last value outside READ. The write port is idle except in WB.
- Opcodes, with N=rdoutN, M=rdoutM, all 8-bit two's complement:
  - 0 NOP: no write, flags unchanged.
  - 1 ADD: N+M, wraps; V = signed overflow.
  - 2 SUB: N-M, wraps; V = signed overflow.
  - 3 AND, 4 OR, 5 XOR: bitwise; V=0.
  - 6 MOVI: rd=imm; V=0; operands ignored.
  - 7 MUL: signed N*M, low 8 bits written; V=1 if the 16-bit product is outside [-128,127].
  - 8 SHL: N<<M[2:0]; V=0.
  - 9 ASR: N>>>M[2:0]; V=0.
  - 10-15 illegal: no write, flags unchanged, illegal_op pulses in WB.
- MUL implementation: magnitudes |N| and |M| in 8-bit unsigned (|-128|=128). Shift-add, one multiplier bit per MUL cycle. Negate the 16-bit product if sign(N) xor sign(M).
- Flags update only on writing ops, in the WB cycle (registered at entry to WB): Z = result==0, N = result[7].
- rd may equal rn or rm; operands are already captured, so a self-overwrite is safe.
- instr_* changes while instr_ready=0 are ignored.

Test Plan:
- R1=100, R2=27, ADD rd=3 rn=1 rm=2 -> wren pulse 3 cycles after handshake, waddr=3, wdin=127; V=0, Z=0, N=0.
- R1=100, R2=28, ADD -> wdin=-128 (0x80), V=1, N=1. Then SUB of R1-R1 -> wdin=0, Z=1, V=0.
- MUL: R4=-12, R5=10 -> wdin=-120 (0x88), V=0. Then R4=16, R5=16 -> wdin=0x00, V=1. Then R4=-128, R5=-1 -> wdin=0x80, V=1. Each writes exactly 11 cycles after handshake.
- MOVI rd=7 imm=-5, then ASR rd=8 rn=7 rm=(reg holding 1) -> R7=0xFB, R8=0xFD. SHL of 0x81 by 1 -> 0x02.
- op=12 -> no wren, illegal_op and done pulse together, flags hold previous values. NOP -> done only.
- Assert resetn low in WB of an ADD -> no write; REGF[rd] unchanged; all outputs at reset values. Back-to-back valid held high -> instr_ready deasserted for READ..WB; exactly one write per instruction.
